// File: rtl/debug_seg_display_if.sv
// Signal bundle between the debug display and its surroundings: channel taps and raw
// buttons in, seven-segment bank and status out.
interface debug_seg_display_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int DIGITS = DATA_W / 4;
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     btn_next;
    logic                     btn_freeze;
    logic [7*DIGITS-1:0]      seg;
    logic [SEL_W-1:0]         ch_sel;
    logic                     frozen;

    modport master (
        output ch_data, btn_next, btn_freeze,
        input  seg, ch_sel, frozen
    );

    modport slave (
        input  ch_data, btn_next, btn_freeze,
        output seg, ch_sel, frozen
    );
endinterface

// File: rtl/debug_seg_display.sv
// Multi-channel hex debug display: two debounced pushbuttons step the shown channel and
// freeze the shown value; the latched word drives the seven-segment bank.
module debug_seg_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic btn_raw_i,
    output logic press_o
);
    localparam int              CNT_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Buttons are active low: a press is the accepted level falling.
    assign press_o = level_q & ~level_d;
endmodule

module debug_seg_display #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLANK_LZ     = 0
) (
    input  logic                clock,
    input  logic                resetn,
    debug_seg_display_if.slave  dbg
);
    localparam int               DIGITS  = DATA_W / 4;
    localparam int               SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_CH - 1);

    logic [DATA_W-1:0]   chan [NUM_CH];
    logic                ev_next;
    logic                ev_freeze;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;
    logic                frozen_q;
    logic                frozen_d;
    logic [DATA_W-1:0]   disp_q;
    logic [DATA_W-1:0]   disp_d;
    logic [7*DIGITS-1:0] seg_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign chan[k] = dbg.ch_data[k*DATA_W +: DATA_W];
    end

    debug_seg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .clock     (clock),
        .resetn    (resetn),
        .btn_raw_i (dbg.btn_next),
        .press_o   (ev_next)
    );

    debug_seg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_freeze (
        .clock     (clock),
        .resetn    (resetn),
        .btn_raw_i (dbg.btn_freeze),
        .press_o   (ev_freeze)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_q    <= '0;
            frozen_q <= 1'b0;
            disp_q   <= '0;
        end else begin
            sel_q    <= sel_d;
            frozen_q <= frozen_d;
            disp_q   <= disp_d;
        end
    end

    // A channel step while frozen takes one snapshot of the newly selected channel.
    always_comb begin
        sel_d = sel_q;
        if (ev_next) begin
            sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
        end
        frozen_d = frozen_q ^ ev_freeze;
        disp_d   = disp_q;
        if (!frozen_d || ev_next) begin
            disp_d = chan[sel_d];
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down so "all higher nibbles zero" accumulates.
    always_comb begin
        logic       upper_zero;
        logic [3:0] nib;
        seg_w      = '0;
        upper_zero = 1'b1;
        nib        = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib        = disp_q[4*d +: 4];
            upper_zero = upper_zero & (nib == 4'h0);
            if ((BLANK_LZ != 0) && (d != 0) && upper_zero) begin
                seg_w[7*d +: 7] = 7'b1111111;
            end else begin
                seg_w[7*d +: 7] = hex7(nib);
            end
        end
    end

    assign dbg.seg    = seg_w;
    assign dbg.ch_sel = sel_q;
    assign dbg.frozen = frozen_q;
endmodule

// File: tb/tb_debug_seg_display.sv
// Bench for debug_seg_display: directed scenarios plus random channel data and button
// activity, all checked each cycle against a behavioural model of the display.
module tb_debug_seg_display;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEB    = 4;
    localparam int DIGITS = 8;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    debug_seg_display_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();
    debug_seg_display_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_b ();

    debug_seg_display #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_CYC(DEB), .BLANK_LZ(0)) dut (
        .clock  (clock),
        .resetn (resetn),
        .dbg    (bus)
    );

    debug_seg_display #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE_CYC(DEB), .BLANK_LZ(1)) dut_b (
        .clock  (clock),
        .resetn (resetn),
        .dbg    (bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_sel;
    bit          m_frz;
    logic [31:0] m_disp;
    logic [31:0] mb_disp;
    bit          acc_n, acc_f;
    int          run_n, run_f;
    bit          hist_n[$];
    bit          hist_f[$];

    string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [55:0] seg_of(input logic [31:0] v, input bit blank);
        logic [55:0] r;
        logic [6:0]  g;
        string       s;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            s = glyph[(v >> (4*d)) & 32'hF];
            g = 7'b1111111;
            for (int c = 0; c < s.len(); c++) g[s[c] - "a"] = 1'b0;
            if (blank && d > 0 && (v >> (4*d)) == 0) g = 7'b1111111;
            r[7*d +: 7] = g;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel   = 0;
        m_frz   = 0;
        m_disp  = '0;
        mb_disp = '0;
        acc_n   = 1;
        acc_f   = 1;
        run_n   = 0;
        run_f   = 0;
        hist_n  = {1'b1, 1'b1};
        hist_f  = {1'b1, 1'b1};
    endtask

    // A level is accepted once the synchronised button has disagreed with the accepted
    // level on DEB consecutive edges.
    task automatic deb_step(input bit synced, input bit acc_i, input int run_i,
                            output bit acc_o, output int run_o, output bit press);
        acc_o = acc_i;
        run_o = run_i;
        press = 0;
        if (synced == acc_i) begin
            run_o = 0;
        end else begin
            run_o = run_i + 1;
            if (run_o == DEB) begin
                acc_o = synced;
                run_o = 0;
                press = !synced;
            end
        end
    endtask

    task automatic model_edge();
        bit sn, sf, pn, pf;
        hist_n.push_back(bus.btn_next);
        hist_f.push_back(bus.btn_freeze);
        sn = hist_n[hist_n.size() - 3];
        sf = hist_f[hist_f.size() - 3];
        if (hist_n.size() > 8) void'(hist_n.pop_front());
        if (hist_f.size() > 8) void'(hist_f.pop_front());
        deb_step(sn, acc_n, run_n, acc_n, run_n, pn);
        deb_step(sf, acc_f, run_f, acc_f, run_f, pf);
        if (pn) m_sel = (m_sel + 1) % NUM_CH;
        if (pf) m_frz = !m_frz;
        if (!m_frz || pn) m_disp = bus.ch_data[m_sel*DATA_W +: DATA_W];
        mb_disp = bus_b.ch_data[31:0];
    endtask

    task automatic check_all();
        chk("seg",     64'(bus.seg),    64'(seg_of(m_disp, 0)));
        chk("ch_sel",  64'(bus.ch_sel), 64'(m_sel));
        chk("frozen",  64'(bus.frozen), 64'(m_frz));
        chk("seg_blz", 64'(bus_b.seg),  64'(seg_of(mb_disp, 1)));
    endtask

    task automatic tick();
        @(posedge clock);
        if (resetn) model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic press_btn(input bit do_next, input bit do_frz, output int lat);
        logic [1:0] p_sel;
        logic       p_frz;
        p_sel = bus.ch_sel;
        p_frz = bus.frozen;
        lat   = -1;
        for (int i = 1; i <= 10; i++) begin
            if (do_next) bus.btn_next = 1'b0;
            if (do_frz)  bus.btn_freeze = 1'b0;
            tick();
            if (lat < 0 && (bus.ch_sel !== p_sel || bus.frozen !== p_frz)) lat = i;
        end
        bus.btn_next   = 1'b1;
        bus.btn_freeze = 1'b1;
        repeat (10) tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_seg",    64'(bus.seg),    64'({DIGITS{7'b1000000}}));
        chk("rst_ch_sel", 64'(bus.ch_sel), 64'(0));
        chk("rst_frozen", 64'(bus.frozen), 64'(0));
        chk("rst_seg_blz", 64'(bus_b.seg), 64'({{(DIGITS-1){7'b1111111}}, 7'b1000000}));
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          low_n, low_f;
        logic [31:0] v;

        resetn           = 1'b1;
        bus.btn_next     = 1'b1;
        bus.btn_freeze   = 1'b1;
        bus.ch_data      = {$urandom, $urandom, $urandom, $urandom};
        bus_b.btn_next   = 1'b1;
        bus_b.btn_freeze = 1'b1;
        bus_b.ch_data    = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        repeat (3) @(negedge clock);
        do_reset();

        // Live display
        bus.ch_data[31:0] = 32'h1234ABCD;
        tick();
        chk("live_1234ABCD", 64'(bus.seg),
            64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}));
        bus.ch_data[31:0] = 32'h0;
        tick();
        chk("live_zero", 64'(bus.seg), 64'({DIGITS{7'b1000000}}));

        // Glitch then four clean presses with wrap
        bus.btn_next = 1'b0;
        repeat (3) tick();
        bus.btn_next = 1'b1;
        repeat (10) tick();
        chk("glitch_no_step", 64'(bus.ch_sel), 64'(0));
        for (int p = 1; p <= 4; p++) begin
            press_btn(1, 0, lat);
            chk("next_latency", 64'(lat), 64'(2 + DEB));
            chk("next_sel", 64'(bus.ch_sel), 64'(p % 4));
        end

        // Freeze, snapshot on step, unfreeze
        press_btn(1, 0, lat);
        bus.ch_data[63:32] = 32'h00000055;
        tick();
        press_btn(0, 1, lat);
        chk("freeze_latency", 64'(lat), 64'(2 + DEB));
        chk("frozen_set", 64'(bus.frozen), 64'(1));
        bus.ch_data[63:32] = 32'hFFFFFFFF;
        repeat (3) tick();
        chk("frozen_hold", 64'(bus.seg), 64'(seg_of(32'h00000055, 0)));
        bus.ch_data[95:64] = 32'hC0FFEE12;
        press_btn(1, 0, lat);
        chk("frozen_step_sel", 64'(bus.ch_sel), 64'(2));
        chk("frozen_stays",    64'(bus.frozen), 64'(1));
        bus.ch_data[95:64] = 32'h0BADF00D;
        repeat (3) tick();
        chk("frozen_snapshot", 64'(bus.seg), 64'(seg_of(32'hC0FFEE12, 0)));
        press_btn(0, 1, lat);
        chk("unfrozen", 64'(bus.frozen), 64'(0));
        chk("unfrozen_live", 64'(bus.seg), 64'(seg_of(32'h0BADF00D, 0)));

        // Simultaneous next + freeze from channel 3
        press_btn(1, 0, lat);
        bus.ch_data[31:0] = 32'h5A5A0F0F;
        press_btn(1, 1, lat);
        chk("both_latency", 64'(lat), 64'(2 + DEB));
        chk("both_sel",     64'(bus.ch_sel), 64'(0));
        chk("both_frozen",  64'(bus.frozen), 64'(1));
        bus.ch_data[31:0] = $urandom;
        repeat (3) tick();
        chk("both_snapshot", 64'(bus.seg), 64'(seg_of(32'h5A5A0F0F, 0)));

        // Leading-zero blanking
        bus_b.ch_data[31:0] = 32'h00000A00;
        repeat (2) tick();
        chk("blz_A00", 64'(bus_b.seg),
            64'({{5{7'b1111111}}, 7'b0001000, 7'b1000000, 7'b1000000}));
        bus_b.ch_data[31:0] = 32'h0;
        repeat (2) tick();
        chk("blz_zero", 64'(bus_b.seg), 64'({{7{7'b1111111}}, 7'b1000000}));

        // Random channel data and button activity, with mid-run resets
        low_n = 0;
        low_f = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 300; c++) begin
                bus.ch_data = {$urandom, $urandom, $urandom, $urandom};
                v = $urandom;
                bus_b.ch_data[31:0] = v >> $urandom_range(0, 31);
                if (low_n == 0 && $urandom_range(0, 15) == 0) low_n = $urandom_range(1, 12);
                if (low_f == 0 && $urandom_range(0, 19) == 0) low_f = $urandom_range(1, 12);
                bus.btn_next   = (low_n == 0);
                bus.btn_freeze = (low_f == 0);
                if (low_n > 0) low_n--;
                if (low_f > 0) low_f--;
                tick();
            end
            do_reset();
        end

        // Button held across reset release is accepted once as a press
        bus.btn_next = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("held_over_reset", 64'(bus.ch_sel), 64'(1));
        bus.btn_next = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
